framebuffer_reader: RTL and testbench
=====================================

Name: framebuffer_reader

Overview:
- Read-side counterpart of the framebuffer write path. Scans the framebuffer BRAM read port in raster order, driven by an external video timing generator.
- Outputs a pixel stream with hsync, vsync and active delayed to line up with the BRAM read latency.
- Owns tear-free channel selection: a requested write-mux select is committed only at a frame boundary and drives the write-mux `sel`.

Parameters:
- FBUF_ADDR_WIDTH, 19, framebuffer address width.
- FBUF_DATA_WIDTH, 8, pixel width.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BRAM_LATENCY, 2, cycles from `fbuf_addr`/`fbuf_en_rd` sampled to `fbuf_rd_data` valid (1..4).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- vid_hsync_in  in  1  timing-generator hsync (active-high).
- vid_vsync_in  in  1  timing-generator vsync (active-high); its rising edge marks a frame start.
- vid_active_in  in  1  timing-generator active-video.
- sel_req  in  1  requested write-channel select.
- fbuf_en_rd  out  1  BRAM read enable.
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM read address.
- fbuf_rd_data  in  FBUF_DATA_WIDTH  BRAM read data.
- pix_data  out  FBUF_DATA_WIDTH  output pixel; 0 outside active video.
- pix_hsync, pix_vsync, pix_active  out  1 each  delayed timing outputs.
- sel_out  out  1  committed select, goes to the write-mux `sel`.
- frame_done  out  1  one-cycle pulse when the last pixel address is issued.
- overrun  out  1  sticky flag: more than H_ACTIVE*V_ACTIVE active cycles in one frame.

Behaviour:
- Reset values: all outputs 0, address counter 0, delay line 0, state WAIT_SYNC.
- Frame-start edge detect: register `vid_vsync_in`; `fs = vid_vsync_in & ~vsync_q`.
- State machine:
  - WAIT_SYNC: no reads issued (`fbuf_en_rd=0`); `pix_*` still delayed. On `fs`: counter:=0, `sel_out:=sel_req`, go to RUN.
  - RUN: each cycle with `vid_active_in=1`: `fbuf_en_rd=1`, `fbuf_addr=counter` (registered, 1-cycle latency), counter+=1.
    - When the issued address equals H_ACTIVE*V_ACTIVE-1: pulse `frame_done` that same cycle, go to DONE.
    - On `fs` in RUN (short frame): counter:=0, `sel_out:=sel_req`, stay in RUN; `overrun` unchanged.
  - DONE: no reads issued. An active cycle in DONE sets `overrun` (cleared only by `rst`) and reads nothing. On `fs`: counter:=0, `sel_out:=sel_req`, go to RUN.
- `sel_out` changes only on `fs` in any state; `sel_req` is ignored at all other times.
- Counter width is FBUF_ADDR_WIDTH. The end value is a compile-time constant; an elaboration check requires H_ACTIVE*V_ACTIVE <= 2^FBUF_ADDR_WIDTH. No wrap inside a frame.
- Latency:
  - Total input-to-output latency L = BRAM_LATENCY+2 cycles: 1 cycle address register, BRAM_LATENCY, 1 cycle output register.
  - hsync, vsync and active pass through an L-stage shift register.
  - `pix_data` = registered `fbuf_rd_data` when the delayed active flag is 1 *and* a read was actually issued for that slot (tracked by the delayed `fbuf_en_rd`); otherwise 0.
- Simultaneous `fs` and active in the same cycle: `fs` wins. The counter resets and that cycle reads address 0, next address 1.
- Reset mid-frame: outputs clear at once (async); reads resume only after the next `fs`.

Decomposition:
- Package `fbuf_pkg`:
  - FBUF_ADDR_WIDTH and FBUF_DATA_WIDTH defaults, shared with the write path and mux.
  - Reader state enum {WAIT_SYNC, RUN, DONE}.
  - Function computing the frame pixel count.
- One sub-module, `delay_line` (parameters WIDTH, DEPTH, async active-high reset), used for the 3-bit timing delay and the read-issued tracking bit.

Test Plan:
- Reset release, then 8 active cycles before any `fs` -> `fbuf_en_rd` stays 0, `pix_data` 0, `pix_active` follows input delayed 4 cycles (BRAM_LATENCY=2).
- `fs`, then a full 640x480 frame, with the BRAM model returning addr[7:0] -> first `pix_data` 0x00 four cycles after the first active input; address 1 gives 0x01; `frame_done` pulses once at address 307199; no `overrun`.
- Frame of 307200 active cycles plus 5 extra -> `overrun`=1 and stays 1 through the next frames until `rst`; no reads in the extra cycles.
- `sel_req` toggled mid-frame -> `sel_out` unchanged until the next `fs` rising edge, then equals `sel_req` the cycle after.
- `rst` asserted mid-line with address ~1000 -> all outputs 0 immediately; after release, no reads until `fs`; next frame starts at address 0.
- `fs` in the same cycle as the first active pixel, and a short frame (`fs` at address 5000) -> first read is address 0; counter restarts at 0 with no `frame_done`.

Source files
------------

// File: rtl/fbuf_pkg.sv
// Shared framebuffer definitions: default bus widths, reader state encoding and frame size helper.
package fbuf_pkg;

    localparam int unsigned FBUF_ADDR_WIDTH_DEF = 19;
    localparam int unsigned FBUF_DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RUN       = 2'd1,
        DONE      = 2'd2
    } reader_state_e;

    function automatic longint unsigned frame_pixels(input int unsigned h_active,
                                                     input int unsigned v_active);
        return 64'(h_active) * 64'(v_active);
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register shift line with asynchronous active-high clear.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/framebuffer_reader.sv
// Raster-order framebuffer read scanner with latency-matched timing outputs
// and frame-boundary commit of the write-mux channel select.
module framebuffer_reader
    import fbuf_pkg::*;
#(
    parameter int unsigned FBUF_ADDR_WIDTH = FBUF_ADDR_WIDTH_DEF,
    parameter int unsigned FBUF_DATA_WIDTH = FBUF_DATA_WIDTH_DEF,
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned BRAM_LATENCY    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vid_hsync_in,
    input  logic                       vid_vsync_in,
    input  logic                       vid_active_in,
    input  logic                       sel_req,
    output logic                       fbuf_en_rd,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rd_data,
    output logic [FBUF_DATA_WIDTH-1:0] pix_data,
    output logic                       pix_hsync,
    output logic                       pix_vsync,
    output logic                       pix_active,
    output logic                       sel_out,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam longint unsigned            NPIX      = frame_pixels(H_ACTIVE, V_ACTIVE);
    localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(NPIX - 64'd1);

    if (NPIX > (64'd1 << FBUF_ADDR_WIDTH)) begin : g_size_check
        $error("framebuffer_reader: H_ACTIVE*V_ACTIVE exceeds address space");
    end
    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_lat_check
        $error("framebuffer_reader: BRAM_LATENCY must be 1..4");
    end

    reader_state_e              state_q, state_d;
    logic                       vsync_q;
    logic [FBUF_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [FBUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       en_q, en_d;
    logic                       done_q, done_d;
    logic                       sel_q, sel_d;
    logic                       ovr_q, ovr_d;
    logic                       fs_c;
    logic                       rd_ok_c;
    logic [FBUF_ADDR_WIDTH-1:0] cnt_eff_c;

    assign fs_c = vid_vsync_in & ~vsync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_SYNC;
            vsync_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vid_vsync_in;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            ovr_q   <= ovr_d;
        end
    end

    // A frame start overrides everything: counter restarts and that same cycle may read address 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        en_d      = 1'b0;
        done_d    = 1'b0;
        sel_d     = sel_q;
        ovr_d     = ovr_q;
        cnt_eff_c = fs_c ? '0 : cnt_q;
        rd_ok_c   = vid_active_in & (fs_c | (state_q == RUN));

        if (fs_c) begin
            state_d = RUN;
            cnt_d   = '0;
            sel_d   = sel_req;
        end

        if (rd_ok_c) begin
            en_d   = 1'b1;
            addr_d = cnt_eff_c;
            cnt_d  = cnt_eff_c + FBUF_ADDR_WIDTH'(1);
            if (cnt_eff_c == LAST_ADDR) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
        end else if (vid_active_in && !fs_c && state_q == DONE) begin
            ovr_d = 1'b1;
        end
    end

    logic [2:0] tim_dly;
    logic       rd_dly;

    // Timing lags one stage short of the output; the final stage is the pixel output register.
    delay_line #(
        .WIDTH(3),
        .DEPTH(BRAM_LATENCY + 1)
    ) u_tim_dly (
        .clk(clk),
        .rst(rst),
        .d_i({vid_active_in, vid_vsync_in, vid_hsync_in}),
        .q_o(tim_dly)
    );

    delay_line #(
        .WIDTH(1),
        .DEPTH(BRAM_LATENCY)
    ) u_rd_dly (
        .clk(clk),
        .rst(rst),
        .d_i(en_q),
        .q_o(rd_dly)
    );

    logic [FBUF_DATA_WIDTH-1:0] pix_data_q;
    logic                       pix_hsync_q;
    logic                       pix_vsync_q;
    logic                       pix_active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data_q   <= '0;
            pix_hsync_q  <= 1'b0;
            pix_vsync_q  <= 1'b0;
            pix_active_q <= 1'b0;
        end else begin
            pix_data_q   <= (tim_dly[2] & rd_dly) ? fbuf_rd_data : '0;
            pix_hsync_q  <= tim_dly[0];
            pix_vsync_q  <= tim_dly[1];
            pix_active_q <= tim_dly[2];
        end
    end

    assign fbuf_en_rd = en_q;
    assign fbuf_addr  = addr_q;
    assign frame_done = done_q;
    assign sel_out    = sel_q;
    assign overrun    = ovr_q;
    assign pix_data   = pix_data_q;
    assign pix_hsync  = pix_hsync_q;
    assign pix_vsync  = pix_vsync_q;
    assign pix_active = pix_active_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Randomized self-checking bench for framebuffer_reader using a small 16x4 frame.
module tb_framebuffer_reader;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 8;
    localparam int unsigned H  = 16;
    localparam int unsigned V  = 4;
    localparam int unsigned BL = 2;
    localparam int          N  = 64;
    localparam int          L  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vid_hsync_in = 1'b0;
    logic          vid_vsync_in = 1'b0;
    logic          vid_active_in = 1'b0;
    logic          sel_req = 1'b0;
    logic          fbuf_en_rd;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_rd_data;
    logic [DW-1:0] pix_data;
    logic          pix_hsync, pix_vsync, pix_active;
    logic          sel_out, frame_done, overrun;

    always #5 clk = ~clk;

    framebuffer_reader #(
        .FBUF_ADDR_WIDTH(AW),
        .FBUF_DATA_WIDTH(DW),
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .BRAM_LATENCY(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid_hsync_in(vid_hsync_in),
        .vid_vsync_in(vid_vsync_in),
        .vid_active_in(vid_active_in),
        .sel_req(sel_req),
        .fbuf_en_rd(fbuf_en_rd),
        .fbuf_addr(fbuf_addr),
        .fbuf_rd_data(fbuf_rd_data),
        .pix_data(pix_data),
        .pix_hsync(pix_hsync),
        .pix_vsync(pix_vsync),
        .pix_active(pix_active),
        .sel_out(sel_out),
        .frame_done(frame_done),
        .overrun(overrun)
    );

    // Two-cycle BRAM whose contents are the low address byte.
    logic [DW-1:0] bram_s1 = '0;
    logic [DW-1:0] bram_s2 = '0;
    always @(posedge clk) begin
        if (fbuf_en_rd) bram_s1 <= fbuf_addr[7:0];
        bram_s2 <= bram_s1;
    end
    assign fbuf_rd_data = bram_s2;

    int n_checks = 0;
    int n_errors = 0;
    int done_pulses = 0;
    bit rand_sel = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act_v, exp_v);
        end
    endtask

    // Reference model: pixels issued per frame, tracked as a count against the frame size.
    bit m_valid = 1'b0;
    bit m_started, m_sel, m_ovr, m_prev_vs, e_en, e_done;
    int m_cnt, e_addr;
    bit h_act[L], h_hs[L], h_vs[L], h_iss[L];
    int h_addr[L];

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1; m_started = 1'b0; m_sel = 1'b0; m_ovr = 1'b0; m_prev_vs = 1'b0;
            e_en = 1'b0; e_done = 1'b0; m_cnt = 0; e_addr = 0;
            for (int i = 0; i < L; i++) begin
                h_act[i] = 1'b0; h_hs[i] = 1'b0; h_vs[i] = 1'b0; h_iss[i] = 1'b0; h_addr[i] = 0;
            end
        end else begin
            bit fs, iss;
            fs = vid_vsync_in && !m_prev_vs;
            m_prev_vs = vid_vsync_in;
            if (fs) begin m_started = 1'b1; m_cnt = 0; m_sel = sel_req; end
            iss = 1'b0;
            if (vid_active_in && m_started) begin
                if (m_cnt < N) begin iss = 1'b1; e_addr = m_cnt; m_cnt++; end
                else m_ovr = 1'b1;
            end
            e_en = iss;
            e_done = iss && (e_addr == N - 1);
            for (int i = L - 1; i > 0; i--) begin
                h_act[i] = h_act[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
                h_iss[i] = h_iss[i-1]; h_addr[i] = h_addr[i-1];
            end
            h_act[0] = vid_active_in; h_hs[0] = vid_hsync_in; h_vs[0] = vid_vsync_in;
            h_iss[0] = iss; h_addr[0] = e_addr;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (rst) begin
                chk("rst_en", 32'(fbuf_en_rd), 0);
                chk("rst_addr", 32'(fbuf_addr), 0);
                chk("rst_pix", 32'({pix_data, pix_hsync, pix_vsync, pix_active}), 0);
                chk("rst_flags", 32'({sel_out, frame_done, overrun}), 0);
            end else begin
                chk("fbuf_en_rd", 32'(fbuf_en_rd), 32'(e_en));
                if (e_en) chk("fbuf_addr", 32'(fbuf_addr), 32'(e_addr));
                chk("frame_done", 32'(frame_done), 32'(e_done));
                chk("sel_out", 32'(sel_out), 32'(m_sel));
                chk("overrun", 32'(overrun), 32'(m_ovr));
                chk("pix_data", 32'(pix_data),
                    (h_act[L-1] && h_iss[L-1]) ? 32'(8'(h_addr[L-1])) : 0);
                chk("pix_hsync", 32'(pix_hsync), 32'(h_hs[L-1]));
                chk("pix_vsync", 32'(pix_vsync), 32'(h_vs[L-1]));
                chk("pix_active", 32'(pix_active), 32'(h_act[L-1]));
                if (frame_done === 1'b1) done_pulses++;
            end
        end
    end

    task automatic cyc(input bit vs, input bit act, input bit hs);
        vid_vsync_in = vs;
        vid_active_in = act;
        vid_hsync_in = hs;
        if (rand_sel) sel_req = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // One frame: vsync pulse, then npix active cycles in lines of H with random gaps and blanking.
    task automatic frame(input int npix, input bit fs_first);
        int sent = 0;
        int in_line = 0;
        int k = 0;
        int pre;
        pre = fs_first ? 0 : 3;
        for (int p = 0; p < pre; p++) begin cyc(k < 2, 1'b0, 1'b0); k++; end
        while (sent < npix) begin
            if (in_line == int'(H)) begin
                int nb;
                nb = int'($urandom_range(1, 3));
                for (int b = 0; b < nb; b++) begin cyc(k < 2, 1'b0, b == 0); k++; end
                in_line = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                cyc(k < 2, 1'b0, 1'b0); k++;
            end else begin
                cyc(k < 2, 1'b1, 1'b0); k++; sent++; in_line++;
            end
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int d0;
        cyc(0, 0, 0);
        chk("lit_reset_en", 32'(fbuf_en_rd), 0);
        chk("lit_reset_ovr", 32'(overrun), 0);
        cyc(0, 0, 0);
        rst = 1'b0;

        // Active video before any frame start: no reads, timing still delayed.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        chk("lit_pre_fs_active", 32'(pix_active), 1);
        chk("lit_pre_fs_data", 32'(pix_data), 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        chk("lit_pre_fs_en", 32'(fbuf_en_rd), 0);
        cyc(0, 0, 0);

        // Full frame with pinned first pixels.
        d0 = done_pulses;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        chk("lit_first_pix_act", 32'(pix_active), 1);
        chk("lit_first_pix", 32'(pix_data), 0);
        cyc(0, 1, 0);
        chk("lit_second_pix", 32'(pix_data), 1);
        for (int i = 0; i < N - 5; i++) cyc(0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);
        chk("lit_done_once", 32'(done_pulses - d0), 1);
        chk("lit_no_ovr", 32'(overrun), 0);

        // Overrun is sticky across frames.
        rand_sel = 1'b1;
        frame(N + 5, 1'b0);
        chk("lit_ovr_set", 32'(overrun), 1);
        frame(N, 1'b0);
        chk("lit_ovr_sticky", 32'(overrun), 1);
        rand_sel = 1'b0;

        // Select commits only on frame start.
        sel_req = 1'b1;
        cyc(1, 0, 0);
        chk("lit_sel_commit1", 32'(sel_out), 1);
        cyc(1, 0, 0);
        sel_req = 1'b0;
        for (int i = 0; i < 10; i++) cyc(0, 1, 0);
        chk("lit_sel_hold", 32'(sel_out), 1);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("lit_sel_commit0", 32'(sel_out), 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 1, 0);

        // Asynchronous reset mid-line.
        rst = 1'b1;
        #1;
        chk("lit_async_en", 32'(fbuf_en_rd), 0);
        chk("lit_async_addr", 32'(fbuf_addr), 0);
        chk("lit_async_ovr", 32'(overrun), 0);
        chk("lit_async_sel", 32'(sel_out), 0);
        chk("lit_async_pact", 32'(pix_active), 0);
        @(posedge clk); #1;
        cyc(0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        chk("lit_post_rst_en", 32'(fbuf_en_rd), 0);
        cyc(0, 0, 0);

        // Frame start coincident with first active pixel, then a short frame.
        d0 = done_pulses;
        cyc(1, 1, 0);
        chk("lit_fs_act_en", 32'(fbuf_en_rd), 1);
        chk("lit_fs_act_addr", 32'(fbuf_addr), 0);
        cyc(1, 1, 0);
        chk("lit_fs_act_addr1", 32'(fbuf_addr), 1);
        for (int i = 0; i < 18; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("lit_short_no_done", 32'(done_pulses - d0), 0);
        frame(N, 1'b0);
        chk("lit_short_then_full", 32'(done_pulses - d0), 1);

        // Randomized frames of varying length.
        rand_sel = 1'b1;
        for (int f = 0; f < 15; f++) begin
            frame(int'($urandom_range(N - 10, N + 3)), 1'($urandom_range(0, 1)));
        end
        rand_sel = 1'b0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
